// File: rtl/ram_pkg.sv
// -----------------------------------------------------------------------------
// ram_pkg
// Shared types and constants for the synchronous two-port RAM and its clear
// sequencer.
//   ram_state_t : clear sequencer states (CLEAR, READY)
//   rdw_mode_t  : same-address read-during-write result selection
//   BYTE_W      : width of one byte-enable lane
// -----------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic {CLEAR, READY} ram_state_t;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_t;

    localparam int BYTE_W = 8;

endpackage : ram_pkg

// File: rtl/ram_clear_fsm.sv
// -----------------------------------------------------------------------------
// ram_clear_fsm
// Zeroes the RAM array one word per cycle after reset or on a clear request.
// Ports:
//   clk        : clock, all state changes on posedge
//   rstN       : asynchronous active-low reset; restarts the clear at address 0
//   i_clr_n    : active-low clear request, only looked at in READY
//   o_clr_we   : write strobe for the clear write (all bytes, zero data)
//   o_clr_addr : address being cleared this cycle
//   o_busy     : high while the clear is in progress
// -----------------------------------------------------------------------------
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int SIZE    = 1024,
    parameter int A_WIDTH = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               i_clr_n,
    output logic               o_clr_we,
    output logic [A_WIDTH-1:0] o_clr_addr,
    output logic               o_busy
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(SIZE - 1);

    ram_state_t         r_state;
    ram_state_t         w_state_nxt;
    logic [A_WIDTH-1:0] r_clr_addr;
    logic [A_WIDTH-1:0] w_clr_addr_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // NOTE: every output of this block is assigned a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            CLEAR: begin
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt    = READY;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            READY: begin
                if (!i_clr_n) begin
                    w_state_nxt    = CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_clr_addr;

endmodule : ram_clear_fsm

// File: rtl/ram_sync_2p.sv
// -----------------------------------------------------------------------------
// ram_sync_2p
// Synchronous simple-dual-port RAM: one write port with byte enables, one read
// port with 1- or 2-cycle latency, selectable read-during-write result and a
// hardware clear sequencer that zeroes the array after reset or on request.
// Ports:
//   clk      : clock
//   rstN     : asynchronous active-low reset
//   clrN     : active-low clear request (ignored while busy)
//   wrN      : active-low write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   wr_be    : byte enables, bit i covers wr_data[8i+7:8i]
//   rdN      : active-low read strobe
//   rd_addr  : read address
//   rd_data  : read data, holds its value between completed reads
//   rd_valid : one-cycle pulse per accepted read, aligned with rd_data
//   busy     : high while clearing; user reads/writes are ignored
// -----------------------------------------------------------------------------
module ram_sync_2p
    import ram_pkg::*;
#(
    parameter int        SIZE       = 1024,
    parameter int        D_WIDTH    = 32,
    parameter int        A_WIDTH    = $clog2(SIZE),
    localparam int       BE_WIDTH   = D_WIDTH / 8,
    parameter int        RD_LATENCY = 1,
    parameter rdw_mode_t RDW_MODE   = RDW_OLD
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                clrN,
    input  logic                wrN,
    input  logic [A_WIDTH-1:0]  wr_addr,
    input  logic [D_WIDTH-1:0]  wr_data,
    input  logic [BE_WIDTH-1:0] wr_be,
    input  logic                rdN,
    input  logic [A_WIDTH-1:0]  rd_addr,
    output logic [D_WIDTH-1:0]  rd_data,
    output logic                rd_valid,
    output logic                busy
);

    // One extra bit so SIZE itself is representable when SIZE is a power of 2.
    localparam logic [A_WIDTH:0] SIZE_W = (A_WIDTH + 1)'(SIZE);

    if ((D_WIDTH % BYTE_W) != 0) begin : g_chk_width
        $error("ram_sync_2p: D_WIDTH must be a multiple of 8");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_chk_latency
        $error("ram_sync_2p: RD_LATENCY must be 1 or 2");
    end

    logic                w_clr_we;
    logic [A_WIDTH-1:0]  w_clr_addr;
    logic                w_busy;

    logic                w_wr_in_range;
    logic                w_rd_in_range;
    logic                w_user_we;
    logic                w_rd_en;

    logic                w_we;
    logic [A_WIDTH-1:0]  w_waddr;
    logic [D_WIDTH-1:0]  w_wdata;
    logic [BE_WIDTH-1:0] w_wbe;
    logic [D_WIDTH-1:0]  w_rd_word;

    logic [D_WIDTH-1:0]  r_mem [SIZE];
    logic [D_WIDTH-1:0]  r_s1_data;
    logic                r_s1_vld;
    logic [D_WIDTH-1:0]  r_rd_data;
    logic                r_rd_valid;

    ram_clear_fsm #(
        .SIZE    (SIZE),
        .A_WIDTH (A_WIDTH)
    ) u_clear_fsm (
        .clk        (clk),
        .rstN       (rstN),
        .i_clr_n    (clrN),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_busy     (w_busy)
    );

    assign w_wr_in_range = ({1'b0, wr_addr} < SIZE_W);
    assign w_rd_in_range = ({1'b0, rd_addr} < SIZE_W);
    assign w_user_we     = !w_busy && !wrN && w_wr_in_range;
    assign w_rd_en       = !w_busy && !rdN;

    // The clear sequencer owns the write port whenever it is active; the user
    // strobe is already gated off by busy, so the two never collide.
    always_comb begin
        w_we    = w_clr_we | w_user_we;
        w_waddr = wr_addr;
        w_wdata = wr_data;
        w_wbe   = wr_be;
        if (w_clr_we) begin
            w_waddr = w_clr_addr;
            w_wdata = '0;
            w_wbe   = '1;
        end
    end

    // Word captured by an accepted read. Out-of-range reads return zero.
    // In RDW_NEW mode a same-address write is merged byte by byte on the way
    // out, since the array itself only updates at the edge.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr];
            if ((RDW_MODE == RDW_NEW) && w_user_we && (wr_addr == rd_addr)) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (wr_be[b]) begin
                        w_rd_word[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // NOTE: the array and its read register carry no reset; zeroing is the
    // clear sequencer's job, which keeps this mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (w_wbe[b]) begin
                    r_mem[w_waddr][b*BYTE_W +: BYTE_W] <= w_wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
        if (w_rd_en) begin
            r_s1_data <= w_rd_word;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_rd_en;
        end
    end

    // Output stage(s). rd_data only moves when a read completes, so it holds
    // the last returned word across idle cycles and across a clear.
    if (RD_LATENCY == 2) begin : g_lat2
        logic               r_s2_vld;
        logic [D_WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                r_s2_vld   <= 1'b0;
                r_s2_data  <= '0;
                r_rd_valid <= 1'b0;
                r_rd_data  <= '0;
            end else begin
                r_s2_vld   <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_data <= r_s1_data;
                end
                r_rd_valid <= r_s2_vld;
                if (r_s2_vld) begin
                    r_rd_data <= r_s2_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                r_rd_valid <= 1'b0;
                r_rd_data  <= '0;
            end else begin
                r_rd_valid <= r_s1_vld;
                if (r_s1_vld) begin
                    r_rd_data <= r_s1_data;
                end
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;

endmodule : ram_sync_2p

// File: tb/tb_ram_sync_2p.sv
// -----------------------------------------------------------------------------
// tb_ram_sync_2p
// Directed bench for ram_sync_2p. Four instances share clock, reset and most
// inputs:
//   u_old : SIZE=16, RD_LATENCY=1, RDW_OLD
//   u_new : SIZE=16, RD_LATENCY=1, RDW_NEW
//   u_l2  : SIZE=16, RD_LATENCY=2, RDW_OLD
//   u_np  : SIZE=12, RD_LATENCY=1, RDW_OLD (non-power-of-2 depth, own wrN)
// -----------------------------------------------------------------------------
module tb_ram_sync_2p;
    import ram_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        clr_n;
    logic        wr_n;
    logic        wr_n_np2;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_n;
    logic [3:0]  rd_addr;

    logic [31:0] d_old, d_new, d_l2, d_np;
    logic        v_old, v_new, v_l2, v_np;
    logic        b_old, b_new, b_l2, b_np;

    int checks = 0;
    int errors = 0;

    ram_sync_2p #(.SIZE(16), .D_WIDTH(32), .RD_LATENCY(1), .RDW_MODE(RDW_OLD)) u_old (
        .clk(clk), .rstN(rst_n), .clrN(clr_n), .wrN(wr_n), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rdN(rd_n), .rd_addr(rd_addr),
        .rd_data(d_old), .rd_valid(v_old), .busy(b_old));

    ram_sync_2p #(.SIZE(16), .D_WIDTH(32), .RD_LATENCY(1), .RDW_MODE(RDW_NEW)) u_new (
        .clk(clk), .rstN(rst_n), .clrN(clr_n), .wrN(wr_n), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rdN(rd_n), .rd_addr(rd_addr),
        .rd_data(d_new), .rd_valid(v_new), .busy(b_new));

    ram_sync_2p #(.SIZE(16), .D_WIDTH(32), .RD_LATENCY(2), .RDW_MODE(RDW_OLD)) u_l2 (
        .clk(clk), .rstN(rst_n), .clrN(clr_n), .wrN(wr_n), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rdN(rd_n), .rd_addr(rd_addr),
        .rd_data(d_l2), .rd_valid(v_l2), .busy(b_l2));

    ram_sync_2p #(.SIZE(12), .D_WIDTH(32), .RD_LATENCY(1), .RDW_MODE(RDW_OLD)) u_np (
        .clk(clk), .rstN(rst_n), .clrN(clr_n), .wrN(wr_n_np2), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rdN(rd_n), .rd_addr(rd_addr),
        .rd_data(d_np), .rd_valid(v_np), .busy(b_np));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, expected completion");
        $fatal(1, "timeout");
    end

    // Wait for the next rising edge and step clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] b2b_val(input int i);
        return 32'h0101_0101 * (i + 1);
    endfunction

    task automatic write_word(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input logic to_main,
                              input logic to_np);
        wr_addr  = addr;
        wr_data  = data;
        wr_be    = be;
        wr_n     = !to_main;
        wr_n_np2 = !to_np;
        tick();
        wr_n     = 1'b1;
        wr_n_np2 = 1'b1;
    endtask

    // One read (optionally with a simultaneous main-port write). ok is high
    // when every instance pulsed rd_valid exactly at its own latency.
    task automatic read_txn(input logic [3:0] addr, input logic with_wr,
                            input logic [3:0] waddr, input logic [31:0] wdata,
                            input logic [3:0] wbe,
                            output logic [31:0] o_old, output logic [31:0] o_new,
                            output logic [31:0] o_l2, output logic [31:0] o_np,
                            output logic ok);
        logic [3:0] pre;
        logic       lat1_ok;
        logic       l2_early;
        rd_n    = 1'b0;
        rd_addr = addr;
        if (with_wr) begin
            wr_n    = 1'b0;
            wr_addr = waddr;
            wr_data = wdata;
            wr_be   = wbe;
        end
        tick();
        rd_n = 1'b1;
        wr_n = 1'b1;
        pre  = {v_old, v_new, v_l2, v_np};
        tick();
        lat1_ok  = v_old & v_new & v_np;
        l2_early = v_l2;
        o_old    = d_old;
        o_new    = d_new;
        o_np     = d_np;
        tick();
        o_l2 = d_l2;
        ok   = (pre === 4'b0) && (lat1_ok === 1'b1) && (l2_early === 1'b0) &&
               (v_l2 === 1'b1) && (v_old === 1'b0);
    endtask

    task automatic test_reset();
        int         cnt_main;
        int         cnt_all;
        int         cnt_np;
        logic [31:0] ro, rn, rl, rp;
        logic        ok;
        rst_n = 1'b0; clr_n = 1'b1; wr_n = 1'b1; wr_n_np2 = 1'b1; rd_n = 1'b1;
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
        repeat (3) tick();
        checks++;
        if ({v_old, v_new, v_l2, v_np} !== 4'b0000 || {b_old, b_new, b_l2, b_np} !== 4'b1111 ||
            (d_old | d_new | d_l2 | d_np) !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: valid=%b busy=%b data_or=%h, expected valid=0000 busy=1111 data_or=00000000",
                     {v_old, v_new, v_l2, v_np}, {b_old, b_new, b_l2, b_np}, d_old | d_new | d_l2 | d_np);
        end
        // Release and hammer address 0 with writes while the clear runs.
        rst_n = 1'b1; wr_n = 1'b0; wr_addr = 4'd0; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
        cnt_main = 0; cnt_all = 0; cnt_np = 0;
        for (int i = 0; i < 20; i++) begin
            cnt_main += int'(b_old);
            cnt_all  += int'(b_old) + int'(b_new) + int'(b_l2);
            cnt_np   += int'(b_np);
            if (!b_old) wr_n = 1'b1;
            tick();
        end
        wr_n = 1'b1;
        checks++;
        if (cnt_main !== 16) begin
            errors++;
            $display("FAIL reset_busy_cycles: got %0d expected 16", cnt_main);
        end
        checks++;
        if (cnt_all !== 48) begin
            errors++;
            $display("FAIL reset_busy_all: got %0d expected 48", cnt_all);
        end
        checks++;
        if (cnt_np !== 12) begin
            errors++;
            $display("FAIL reset_busy_np2: got %0d expected 12", cnt_np);
        end
        for (int a = 0; a < 16; a++) begin
            read_txn(4'(a), 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
            checks++;
            if (!ok || (ro | rn | rl | rp) !== 32'h0) begin
                errors++;
                $display("FAIL reset_read_zero[%0d]: ok=%b data_or=%h expected ok=1 data_or=00000000",
                         a, ok, ro | rn | rl | rp);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] ro, rn, rl, rp;
        logic        ok;
        write_word(4'd3, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0);
        write_word(4'd3, 32'h1122_3344, 4'b0101, 1'b1, 1'b0);
        read_txn(4'd3, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || ro !== 32'hAA22_CC44 || rn !== 32'hAA22_CC44 || rl !== 32'hAA22_CC44) begin
            errors++;
            $display("FAIL byte_enable: ok=%b old=%h new=%h l2=%h expected AA22CC44", ok, ro, rn, rl);
        end
        // All enables low: legal no-op.
        write_word(4'd3, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0);
        read_txn(4'd3, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || ro !== 32'hAA22_CC44 || rn !== 32'hAA22_CC44 || rl !== 32'hAA22_CC44) begin
            errors++;
            $display("FAIL be_zero_noop: ok=%b old=%h new=%h l2=%h expected AA22CC44", ok, ro, rn, rl);
        end
    endtask

    task automatic test_rdw();
        logic [31:0] ro, rn, rl, rp;
        logic        ok;
        write_word(4'd5, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
        read_txn(4'd5, 1'b1, 4'd5, 32'hCAFE_F00D, 4'b0011, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || ro !== 32'h1234_5678 || rn !== 32'h1234_F00D || rl !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rdw_same_addr: ok=%b old=%h new=%h l2=%h expected 12345678/1234F00D/12345678",
                     ok, ro, rn, rl);
        end
        read_txn(4'd5, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || ro !== 32'h1234_F00D || rn !== 32'h1234_F00D || rl !== 32'h1234_F00D) begin
            errors++;
            $display("FAIL rdw_followup: ok=%b old=%h new=%h l2=%h expected 1234F00D", ok, ro, rn, rl);
        end
        // Different addresses in the same cycle must not interact.
        read_txn(4'd5, 1'b1, 4'd6, 32'h0BAD_BEEF, 4'hF, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || ro !== 32'h1234_F00D || rn !== 32'h1234_F00D || rl !== 32'h1234_F00D) begin
            errors++;
            $display("FAIL rdw_diff_addr: ok=%b old=%h new=%h l2=%h expected 1234F00D", ok, ro, rn, rl);
        end
        read_txn(4'd6, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || ro !== 32'h0BAD_BEEF || rn !== 32'h0BAD_BEEF || rl !== 32'h0BAD_BEEF) begin
            errors++;
            $display("FAIL rdw_diff_write: ok=%b old=%h new=%h l2=%h expected 0BADBEEF", ok, ro, rn, rl);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] ro, rn, rl, rp;
        logic        ok;
        write_word(4'd2,  32'hA1B2_C3D4, 4'hF, 1'b0, 1'b1);
        write_word(4'd11, 32'h7777_1111, 4'hF, 1'b0, 1'b1);
        write_word(4'd14, 32'h9999_9999, 4'hF, 1'b0, 1'b1);
        read_txn(4'd14, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || rp !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_14: ok=%b np=%h expected ok=1 np=00000000", ok, rp);
        end
        read_txn(4'd12, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || rp !== 32'h0) begin
            errors++;
            $display("FAIL oor_read_12: ok=%b np=%h expected ok=1 np=00000000", ok, rp);
        end
        read_txn(4'd11, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || rp !== 32'h7777_1111 || ro !== 32'h0) begin
            errors++;
            $display("FAIL inrange_last: ok=%b np=%h old=%h expected np=77771111 old=00000000", ok, rp, ro);
        end
        read_txn(4'd2, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || rp !== 32'hA1B2_C3D4) begin
            errors++;
            $display("FAIL np2_read_2: ok=%b np=%h expected A1B2C3D4", ok, rp);
        end
    endtask

    task automatic test_back_to_back();
        logic        e1, e2;
        logic [31:0] x1, x2;
        for (int i = 0; i < 8; i++) write_word(4'(i), b2b_val(i), 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                rd_n    = 1'b0;
                rd_addr = 4'(i);
            end else begin
                rd_n = 1'b1;
            end
            tick();
            e2 = (i + 1 >= 3) && (i + 1 <= 10);
            x2 = e2 ? b2b_val(i - 2) : 32'h0;
            e1 = (i + 1 >= 2) && (i + 1 <= 9);
            x1 = e1 ? b2b_val(i - 1) : 32'h0;
            checks++;
            if (v_l2 !== e2 || (e2 && d_l2 !== x2)) begin
                errors++;
                $display("FAIL b2b_lat2[%0d]: valid=%b data=%h expected valid=%b data=%h", i, v_l2, d_l2, e2, x2);
            end
            checks++;
            if (v_old !== e1 || (e1 && d_old !== x1)) begin
                errors++;
                $display("FAIL b2b_lat1[%0d]: valid=%b data=%h expected valid=%b data=%h", i, v_old, d_old, e1, x1);
            end
        end
    endtask

    task automatic test_clear_request();
        int          cnt_busy;
        int          cnt_l2;
        logic        ev;
        logic [31:0] ro, rn, rl, rp;
        logic        ok;
        // Read of address 3 sampled together with the clear request.
        clr_n = 1'b0; rd_n = 1'b0; rd_addr = 4'd3;
        tick();
        clr_n = 1'b1; rd_n = 1'b1;
        cnt_busy = 0; cnt_l2 = 0;
        for (int i = 0; i < 20; i++) begin
            cnt_busy += int'(b_old);
            cnt_l2   += int'(b_l2);
            ev = (i == 1);
            checks++;
            if (v_old !== ev || (ev && d_old !== 32'h0404_0404)) begin
                errors++;
                $display("FAIL clear_rd_valid[%0d]: valid=%b data=%h expected valid=%b data=04040404",
                         i, v_old, d_old, ev);
            end
            if (i == 3) begin
                rd_n = 1'b0; rd_addr = 4'd1;
            end else begin
                rd_n = 1'b1;
            end
            tick();
        end
        checks++;
        if (cnt_busy !== 16 || cnt_l2 !== 16) begin
            errors++;
            $display("FAIL clear_busy_cycles: got %0d/%0d expected 16/16", cnt_busy, cnt_l2);
        end
        for (int a = 0; a < 16; a++) begin
            read_txn(4'(a), 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
            checks++;
            if (!ok || (ro | rn | rl | rp) !== 32'h0) begin
                errors++;
                $display("FAIL clear_read_zero[%0d]: ok=%b data_or=%h expected ok=1 data_or=00000000",
                         a, ok, ro | rn | rl | rp);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int          cnt_busy;
        logic [31:0] ro, rn, rl, rp;
        logic        ok;
        write_word(4'd9, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b0);
        clr_n = 1'b0; rd_n = 1'b0; rd_addr = 4'd9;
        tick();
        clr_n = 1'b1; rd_n = 1'b1;
        tick();
        checks++;
        if (v_old !== 1'b1 || d_old !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL midclr_pre_read: valid=%b data=%h expected valid=1 data=5A5A5A5A", v_old, d_old);
        end
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v_old, v_new, v_l2} !== 3'b000 || (d_old | d_new | d_l2) !== 32'h0) begin
            errors++;
            $display("FAIL midclr_async_reset: valid=%b data_or=%h expected valid=000 data_or=00000000",
                     {v_old, v_new, v_l2}, d_old | d_new | d_l2);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        cnt_busy = 0;
        for (int i = 0; i < 20; i++) begin
            cnt_busy += int'(b_old);
            tick();
        end
        checks++;
        if (cnt_busy !== 16) begin
            errors++;
            $display("FAIL midclr_busy_cycles: got %0d expected 16", cnt_busy);
        end
        read_txn(4'd9, 1'b0, 4'd0, 32'h0, 4'h0, ro, rn, rl, rp, ok);
        checks++;
        if (!ok || (ro | rn | rl) !== 32'h0) begin
            errors++;
            $display("FAIL midclr_read_zero: ok=%b data_or=%h expected ok=1 data_or=00000000", ok, ro | rn | rl);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_rdw();
        test_out_of_range();
        test_back_to_back();
        test_clear_request();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_sync_2p
